// File: rtl/scc_mem_pkg.sv
// Shared types and helpers for the Harvard memory controller.
package scc_mem_pkg;

   localparam int unsigned WORD_W         = 32;
   localparam int unsigned IMEM_WORDS_DEF = 256;
   localparam int unsigned DMEM_WORDS_DEF = 256;

   typedef enum logic {LOAD, RUN} state_t;

   // An access is legal when word aligned and inside the memory.
   function automatic logic addr_legal(input logic [WORD_W-1:0] addr, input int unsigned depth);
      return (addr[1:0] == 2'b00) && ({2'b00, addr[WORD_W-1:2]} < WORD_W'(depth));
   endfunction

   function automatic int unsigned idx_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/scc_sync_ram.sv
// Single write port RAM with a registered, write-first read port whose output
// can be forced to zero and is cleared by reset (array contents are not).
module scc_sync_ram
   import scc_mem_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic              re,
   input  logic              rzero,
   input  logic [AW-1:0]     raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read holds when not enabled; same-address write is bypassed to the read.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else if (re) begin
         if (rzero)                        rdata <= '0;
         else if (we && (waddr == raddr))  rdata <= wdata;
         else                              rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/scc_mem_ctrl.sv
// Harvard instruction/data memory controller with a program-load front end
// that holds the core in reset until the image has been written.
module scc_mem_ctrl
   import scc_mem_pkg::*;
#(
   parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEF,
   parameter int unsigned DMEM_WORDS = DMEM_WORDS_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] in_mem_addr,
   input  logic              in_mem_en,
   output logic [WORD_W-1:0] in_mem,
   input  logic [WORD_W-1:0] data_addr,
   input  logic [WORD_W-1:0] data_out,
   input  logic              data_read,
   input  logic              data_write,
   output logic [WORD_W-1:0] data_in,
   input  logic              load_valid,
   input  logic [WORD_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              cpu_reset,
   output logic              addr_fault,
   output logic [WORD_W-1:0] fault_addr
);

   localparam int unsigned IAW = idx_w(IMEM_WORDS);
   localparam int unsigned DAW = idx_w(DMEM_WORDS);

   state_t         state;
   logic [IAW-1:0] load_ptr;

   logic i_legal, d_legal, run;
   logic load_acc, fetch_en, d_rd_en, d_wr_en;
   logic fetch_fault, data_fault;

   assign run         = (state == RUN) && !reset;
   assign i_legal     = addr_legal(in_mem_addr, IMEM_WORDS);
   assign d_legal     = addr_legal(data_addr, DMEM_WORDS);
   assign load_acc    = (state == LOAD) && !reset && load_ready && load_valid;
   assign fetch_en    = run && in_mem_en;
   assign d_rd_en     = run && data_read;
   assign d_wr_en     = run && data_write && d_legal;
   assign fetch_fault = run && in_mem_en && !i_legal;
   assign data_fault  = run && (data_read || data_write) && !d_legal;

   scc_sync_ram #(.DEPTH(IMEM_WORDS), .AW(IAW)) u_imem (
      .clk   (clk),
      .reset (reset),
      .we    (load_acc),
      .waddr (load_ptr),
      .wdata (load_data),
      .re    (fetch_en),
      .rzero (!i_legal),
      .raddr (in_mem_addr[IAW+1:2]),
      .rdata (in_mem)
   );

   scc_sync_ram #(.DEPTH(DMEM_WORDS), .AW(DAW)) u_dmem (
      .clk   (clk),
      .reset (reset),
      .we    (d_wr_en),
      .waddr (data_addr[DAW+1:2]),
      .wdata (data_out),
      .re    (d_rd_en),
      .rzero (!d_legal),
      .raddr (data_addr[DAW+1:2]),
      .rdata (data_in)
   );

   // LOAD/RUN sequencing; the load pointer parks on the last word, never wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= LOAD;
         load_ptr   <= '0;
         load_ready <= 1'b0;
         cpu_reset  <= 1'b1;
         addr_fault <= 1'b0;
         fault_addr <= '0;
      end else begin
         case (state)
            LOAD: begin
               load_ready <= 1'b1;
               cpu_reset  <= 1'b1;
               if (load_acc) begin
                  if (load_last || (load_ptr == IAW'(IMEM_WORDS - 1))) begin
                     state      <= RUN;
                     load_ready <= 1'b0;
                     cpu_reset  <= 1'b0;
                  end else begin
                     load_ptr <= load_ptr + IAW'(1);
                  end
               end
            end
            RUN: begin
               load_ready <= 1'b0;
               cpu_reset  <= 1'b0;
            end
            default: state <= LOAD;
         endcase

         // First fault only; a fetch fault outranks a same-cycle data fault.
         if (!addr_fault && (fetch_fault || data_fault)) begin
            addr_fault <= 1'b1;
            fault_addr <= fetch_fault ? in_mem_addr : data_addr;
         end
      end
   end

endmodule

// File: tb/tb_scc_mem_ctrl.sv
// Directed bench for scc_mem_ctrl: load sequencing, fetch/data paths, faults
// and reset behaviour, with hand-computed expected values.
module tb_scc_mem_ctrl;

   logic        clk;
   logic        reset;
   logic [31:0] in_mem_addr;
   logic        in_mem_en;
   logic [31:0] in_mem;
   logic [31:0] data_addr;
   logic [31:0] data_out;
   logic        data_read;
   logic        data_write;
   logic [31:0] data_in;
   logic        load_valid;
   logic [31:0] load_data;
   logic        load_last;
   logic        load_ready;
   logic        cpu_reset;
   logic        addr_fault;
   logic [31:0] fault_addr;

   int n_checks = 0;
   int n_errors = 0;

   scc_mem_ctrl #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_mem_addr (in_mem_addr),
      .in_mem_en   (in_mem_en),
      .in_mem      (in_mem),
      .data_addr   (data_addr),
      .data_out    (data_out),
      .data_read   (data_read),
      .data_write  (data_write),
      .data_in     (data_in),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_last   (load_last),
      .load_ready  (load_ready),
      .cpu_reset   (cpu_reset),
      .addr_fault  (addr_fault),
      .fault_addr  (fault_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_mem_addr = '0; in_mem_en = 1'b0;
      data_addr = '0; data_out = '0; data_read = 1'b0; data_write = 1'b0;
      load_valid = 1'b0; load_data = '0; load_last = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      chk({tag, "_in_mem"}, in_mem, 32'h0);
      chk({tag, "_data_in"}, data_in, 32'h0);
      chk({tag, "_addr_fault"}, {31'b0, addr_fault}, 32'h0);
      chk({tag, "_fault_addr"}, fault_addr, 32'h0);
      chk({tag, "_load_ready"}, {31'b0, load_ready}, 32'h0);
      chk({tag, "_cpu_reset"}, {31'b0, cpu_reset}, 32'h1);
      reset = 1'b0;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 8 && !load_ready; i++) tick();
      chk("load_ready_wait", {31'b0, load_ready}, 32'h1);
   endtask

   task automatic load_word(input logic [31:0] d, input logic last);
      load_valid = 1'b1; load_data = d; load_last = last;
      tick();
      load_valid = 1'b0; load_last = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a);
      in_mem_addr = a; in_mem_en = 1'b1;
      tick();
      in_mem_en = 1'b0;
   endtask

   task automatic dacc(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] d);
      data_addr = a; data_read = rd; data_write = wr; data_out = d;
      tick();
      data_read = 1'b0; data_write = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      do_reset("rst0");

      // Short load with core-side traffic that must be ignored while loading
      wait_ready();
      chk("load_cpu_reset", {31'b0, cpu_reset}, 32'h1);
      in_mem_addr = 32'h3; in_mem_en = 1'b1;
      data_addr = 32'h3; data_read = 1'b1; data_write = 1'b1;
      load_word(32'h11, 1'b0);
      load_word(32'h22, 1'b0);
      chk("load_in_mem_zero", in_mem, 32'h0);
      chk("load_data_in_zero", data_in, 32'h0);
      chk("load_no_fault", {31'b0, addr_fault}, 32'h0);
      idle_inputs();
      load_word(32'h33, 1'b1);
      chk("last_load_ready", {31'b0, load_ready}, 32'h0);
      chk("last_cpu_reset", {31'b0, cpu_reset}, 32'h0);

      // Fetch path
      fetch(32'h8);
      chk("fetch_8", in_mem, 32'h33);
      fetch(32'h0);
      chk("fetch_0", in_mem, 32'h11);
      in_mem_addr = 32'h4;
      tick();
      chk("fetch_hold", in_mem, 32'h11);
      fetch(32'h4);
      chk("fetch_4", in_mem, 32'h22);

      // Data path: write then read, write-first same cycle, hold
      dacc(32'h10, 1'b0, 1'b1, 32'hDEADBEEF);
      dacc(32'h10, 1'b1, 1'b0, 32'h0);
      chk("rd_after_wr", data_in, 32'hDEADBEEF);
      dacc(32'h14, 1'b1, 1'b1, 32'h0000CAFE);
      chk("rw_same", data_in, 32'h0000CAFE);
      data_addr = 32'h10;
      tick();
      chk("data_hold", data_in, 32'h0000CAFE);
      dacc(32'h3FC, 1'b0, 1'b1, 32'h77);
      dacc(32'h3FC, 1'b1, 1'b0, 32'h0);
      chk("rd_top_word", data_in, 32'h77);
      chk("no_fault_yet", {31'b0, addr_fault}, 32'h0);

      // Faults: misaligned read, out-of-range write aliasing word 0
      dacc(32'h0, 1'b0, 1'b1, 32'h1234);
      dacc(32'h3, 1'b1, 1'b0, 32'h0);
      chk("bad_rd_zero", data_in, 32'h0);
      chk("fault_set", {31'b0, addr_fault}, 32'h1);
      chk("fault_addr_3", fault_addr, 32'h3);
      dacc(32'h400, 1'b0, 1'b1, 32'h00000BAD);
      chk("fault_addr_kept", fault_addr, 32'h3);
      dacc(32'h0, 1'b1, 1'b0, 32'h0);
      chk("dmem_unchanged", data_in, 32'h1234);
      fetch(32'h400);
      chk("bad_fetch_zero", in_mem, 32'h0);
      chk("fault_addr_kept2", fault_addr, 32'h3);

      // Reset mid-load: restart at index 0, index 1 keeps its old contents
      do_reset("rst1");
      wait_ready();
      load_word(32'h55, 1'b0);
      load_word(32'h66, 1'b0);
      do_reset("rst2");
      wait_ready();
      load_word(32'hAA, 1'b1);
      chk("reload_cpu_reset", {31'b0, cpu_reset}, 32'h0);
      fetch(32'h0);
      chk("reload_imem0", in_mem, 32'hAA);
      fetch(32'h4);
      chk("reload_imem1", in_mem, 32'h66);
      fetch(32'h8);
      chk("reload_imem2", in_mem, 32'h33);
      dacc(32'h10, 1'b1, 1'b0, 32'h0);
      chk("dmem_survives_reset", data_in, 32'hDEADBEEF);
      chk("reload_no_fault", {31'b0, addr_fault}, 32'h0);

      // Same-cycle fetch and data fault: fetch address wins
      in_mem_addr = 32'h402; in_mem_en = 1'b1;
      data_addr = 32'h5; data_read = 1'b1;
      tick();
      idle_inputs();
      chk("dual_fault", {31'b0, addr_fault}, 32'h1);
      chk("dual_fault_addr", fault_addr, 32'h402);

      // Full-depth load without load_last, then a stray extra word
      do_reset("rst3");
      wait_ready();
      for (int i = 0; i < 256; i++) begin
         if (i == 255) chk("full_ready_255", {31'b0, load_ready}, 32'h1);
         load_word(32'h100 + 32'(i), 1'b0);
      end
      chk("full_load_ready", {31'b0, load_ready}, 32'h0);
      chk("full_cpu_reset", {31'b0, cpu_reset}, 32'h0);
      load_word(32'h00000BAD, 1'b0);
      fetch(32'h3FC);
      chk("full_imem255", in_mem, 32'h1FF);
      fetch(32'h0);
      chk("full_imem0", in_mem, 32'h100);
      fetch(32'h200);
      chk("full_imem128", in_mem, 32'h180);
      chk("full_no_fault", {31'b0, addr_fault}, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/scc_mem_ctrl.md
SCC_MEM_CTRL -- requirements
Module: scc_mem_ctrl

Interface
REQ-001 Parameter IMEM_WORDS, default 256, instruction memory depth in 32-bit words.
REQ-002 Parameter DMEM_WORDS, default 256, data memory depth in 32-bit words.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-004 Ports, as name, direction, width, meaning:
- clk, in, 1: single clock.
- reset, in, 1: synchronous, active-high.
- in_mem_addr, in, 32: instruction fetch byte address from the core.
- in_mem_en, in, 1: fetch enable.
- in_mem, out, 32: fetched instruction.
- data_addr, in, 32: data byte address.
- data_out, in, 32: write data from the core.
- data_read, in, 1: data read strobe.
- data_write, in, 1: data write strobe.
- data_in, out, 32: read data to the core.
- load_valid, in, 1: program-load word valid.
- load_data, in, 32: program-load word.
- load_last, in, 1: final load word.
- load_ready, out, 1: program-load word accepted.
- cpu_reset, out, 1: holds the core in reset while loading.
- addr_fault, out, 1: sticky address fault.
- fault_addr, out, 32: byte address of the first fault.

Function
REQ-005 Memory SHALL be Harvard: instruction and data spaces are separate, and each starts at byte address 0.
REQ-006 Word index SHALL be addr[log2(depth)+1:2]; an access is legal only if addr[1:0]==0 and addr < 4*depth.
REQ-007 FSM states SHALL be LOAD and RUN; the FSM SHALL enter LOAD on reset.
REQ-008 In LOAD, load_ready=1 and cpu_reset=1; each cycle with load_valid high SHALL write load_data to imem[load_ptr] and increment load_ptr.
REQ-009 LOAD->RUN SHALL occur after the accepted word that has load_last=1 or that has load_ptr==IMEM_WORDS-1, whichever comes first; load_ptr never wraps.
REQ-010 In RUN, load_ready=0, cpu_reset=0, and load inputs SHALL be ignored; RUN persists until reset.
REQ-011 In LOAD, all core-side inputs SHALL be ignored, and in_mem and data_in SHALL hold 0.
REQ-012 Fetch: in RUN, a cycle with in_mem_en=1 at a legal address SHALL present imem[index] on in_mem at the next edge (latency 1); with in_mem_en=0, in_mem SHALL hold its value.
REQ-013 Data read: data_read=1 at a legal address SHALL present dmem[index] on data_in at the next edge (latency 1); with data_read=0, data_in SHALL hold.
REQ-014 Data write: data_write=1 at a legal address SHALL write data_out to dmem[index] at the edge.
REQ-015 When data_read and data_write are both high to the same legal address, behaviour SHALL be write-first: data_in shows data_out one cycle later.
REQ-016 A write at cycle n followed by a read of the same address at cycle n+1 SHALL return the new value.
REQ-017 Illegal fetch or read SHALL return 0 at latency 1; an illegal write SHALL be suppressed, leaving memory unchanged.
REQ-018 Any illegal enabled access in RUN SHALL set addr_fault=1 (sticky until reset).
REQ-019 fault_addr SHALL capture the address of the first fault only; on a same-cycle fetch and data fault, the fetch address wins.
REQ-020 Fetch and data accesses SHALL proceed concurrently with no stalls.

Reset
REQ-021 Reset SHALL dominate all other inputs.
REQ-022 During reset, outputs SHALL be: in_mem=0, data_in=0, addr_fault=0, fault_addr=0, load_ready=0, cpu_reset=1.
REQ-023 Reset SHALL also set state=LOAD and load_ptr=0.
REQ-024 Memory contents SHALL NOT be cleared by reset.
REQ-025 Reset mid-load SHALL restart loading at index 0; already written words remain until overwritten.

Structure
REQ-026 Package scc_mem_pkg SHALL hold: word width 32, default depths, and the state enum {LOAD, RUN}.
REQ-027 Sub-module scc_sync_ram (one write port, one synchronous write-first read port, parameterised depth) SHALL be instantiated once for imem and once for dmem.

Verification
REQ-028 Load 3 words 0x11, 0x22, 0x33 (last on 3rd) -> load_ready drops and cpu_reset=0 on the next cycle; fetch 0x8 -> in_mem=0x33 one cycle later.
REQ-029 Load IMEM_WORDS words without load_last -> RUN is entered after word 255; a 257th load_valid is ignored.
REQ-030 Write 0xDEADBEEF to data address 0x10, then read 0x10 next cycle -> data_in=0xDEADBEEF; simultaneous read+write of 0x14 with 0xCAFE -> data_in=0xCAFE.
REQ-031 Read 0x3 then write to 0x400 -> the read returns 0, addr_fault=1, fault_addr=0x3, dmem is unchanged, and fault_addr stays 0x3.
REQ-032 Assert reset after 2 load words, then load 0xAA -> imem[0]=0xAA, imem[1] retains its old value, and addr_fault=0.
